ram_acc_arbiter: RTL and testbench

RAM_ACC_ARBITER -- requirements
Module: ram_acc_arbiter

---
 rtl/ram_acc_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ram_acc_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_acc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_acc_arbiter
//  Purpose  : Round-robin arbiter that lets NUM_REQ requesters share a single
//             CSR-to-RAM bridge. It serves one access at a time and runs an
//             optional ack watchdog while waiting for the bridge.
//  Ports    : i_clk, i_sync_rst_n             - clock, sync active-low reset
//             i_req / i_req_is_wr             - per-requester request + op
//             i_byte_addr / i_wr_data /
//             i_wr_bit_en                     - packed per-requester fields
//             o_ack / o_err / o_rd_data       - completion back to the owner
//             o_acc_req ... o_wr_bit_en       - request toward the bridge
//             i_rd_ack / i_rd_data / i_wr_ack - bridge responses
//             o_busy / o_gnt_id               - arbiter status
//  Revision : 1.0 - initial release
// ============================================================================
module ram_acc_arbiter #(
  parameter int NUM_REQ             = 2,
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int BYTE_ADDR_BIT_WIDTH = 5,
  parameter int TIMEOUT_CYCLES      = 15,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int W  = WORD_BIT_WIDTH,
  localparam int A  = BYTE_ADDR_BIT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_sync_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_req_is_wr,
  input  logic [NUM_REQ*A-1:0] i_byte_addr,
  input  logic [NUM_REQ*W-1:0] i_wr_data,
  input  logic [NUM_REQ*W-1:0] i_wr_bit_en,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_err,
  output logic [W-1:0]         o_rd_data,
  output logic                 o_acc_req,
  output logic                 o_acc_req_is_wr,
  output logic [A-1:0]         o_byte_addr,
  output logic [W-1:0]         o_wr_data,
  output logic [W-1:0]         o_wr_bit_en,
  input  logic                 i_rd_ack,
  input  logic [W-1:0]         i_rd_data,
  input  logic                 i_wr_ack,
  output logic                 o_busy,
  output logic [GW-1:0]        o_gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Watchdog counter is at least one bit wide even when the watchdog is off.
  localparam int              CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0]   LAST_IDX  = GW'(NUM_REQ - 1);
  localparam logic [GW:0]     NUM_REQ_W = (GW + 1)'(NUM_REQ);

  state_t         state_q, state_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]  owner_q, owner_d;
  logic           is_wr_q, is_wr_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [W-1:0]   bit_en_q, bit_en_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [W-1:0]   rd_data_q, rd_data_d;

  // Round-robin search: scan requesters starting at rr_ptr, wrapping once.
  // cand is one bit wider than the index so rr_ptr + k never overflows
  // before the wrap subtraction.
  logic [GW:0]    cand;
  logic           win_found;
  logic [GW-1:0]  win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && i_req[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  logic w_match_ack;
  logic w_wd_expired;

  // Only the ack type that matches the latched op completes the access.
  assign w_match_ack  = is_wr_q ? i_wr_ack : i_rd_ack;
  assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bit_en_d  = bit_en_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      S_IDLE: begin
        // Requester fields are captured only here; later input changes
        // cannot disturb the access in flight.
        if (win_found) begin
          state_d  = S_ISSUE;
          owner_d  = win_idx;
          is_wr_d  = i_req_is_wr[win_idx];
          addr_d   = i_byte_addr[int'(win_idx) * A +: A];
          wdata_d  = i_wr_data[int'(win_idx) * W +: W];
          bit_en_d = i_wr_bit_en[int'(win_idx) * W +: W];
          rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
        cnt_d   = '0;
      end
      S_WAIT_ACK: begin
        // A matching ack wins over a watchdog expiry in the same cycle.
        if (w_match_ack) begin
          state_d   = S_DONE;
          err_d     = 1'b0;
          rd_data_d = is_wr_q ? '0 : i_rd_data;
        end else if (w_wd_expired) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          rd_data_d = '0;
        end else if (cnt_q != CNT_LIMIT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bit_en_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bit_en_q  <= bit_en_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  logic [NUM_REQ-1:0] w_owner_onehot;
  assign w_owner_onehot = NUM_REQ'(1) << owner_q;

  assign o_acc_req       = (state_q == S_ISSUE);
  assign o_acc_req_is_wr = is_wr_q;
  assign o_byte_addr     = addr_q;
  assign o_wr_data       = wdata_q;
  assign o_wr_bit_en     = bit_en_q;
  assign o_rd_data       = rd_data_q;
  assign o_ack           = (state_q == S_DONE) ? w_owner_onehot : '0;
  assign o_err           = ((state_q == S_DONE) && err_q) ? w_owner_onehot : '0;
  assign o_busy          = (state_q != S_IDLE);
  assign o_gnt_id        = (state_q == S_IDLE) ? '0 : owner_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_acc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_acc_arbiter
//  Purpose  : Directed self-checking bench for ram_acc_arbiter (2 requesters,
//             32-bit words, 5-bit addresses, 15-cycle watchdog). Stimulus
//             pushes expected bridge requests and completions into queues; a
//             monitor pops and compares whenever the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_acc_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_is_wr;
  logic [9:0]  byte_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_bit_en;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rd_data;
  logic        acc_req;
  logic        acc_is_wr;
  logic [4:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] acc_be;
  logic        rd_ack;
  logic [31:0] br_rd_data;
  logic        wr_ack;
  logic        busy;
  logic [0:0]  gnt_id;

  ram_acc_arbiter #(
    .NUM_REQ(2), .WORD_BIT_WIDTH(32), .BYTE_ADDR_BIT_WIDTH(5), .TIMEOUT_CYCLES(15)
  ) dut (
    .i_clk(clk), .i_sync_rst_n(rst_n),
    .i_req(req), .i_req_is_wr(req_is_wr), .i_byte_addr(byte_addr),
    .i_wr_data(wr_data), .i_wr_bit_en(wr_bit_en),
    .o_ack(ack), .o_err(err), .o_rd_data(rd_data),
    .o_acc_req(acc_req), .o_acc_req_is_wr(acc_is_wr), .o_byte_addr(acc_addr),
    .o_wr_data(acc_wdata), .o_wr_bit_en(acc_be),
    .i_rd_ack(rd_ack), .i_rd_data(br_rd_data), .i_wr_ack(wr_ack),
    .o_busy(busy), .o_gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic        is_wr;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] be;
    int          cyc;   // -1 = cycle not checked
  } acc_t;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rd;
    int          cyc;   // -1 = cycle not checked
  } ack_t;

  acc_t acc_q[$];
  ack_t ack_q[$];
  acc_t ea;
  ack_t eb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_acc(input int id, input logic is_wr, input logic [4:0] addr,
                          input logic [31:0] wd, input logic [31:0] be, input int c);
    acc_t e;
    e.id = id; e.is_wr = is_wr; e.addr = addr; e.wd = wd; e.be = be; e.cyc = c;
    acc_q.push_back(e);
  endtask

  task automatic push_ack(input int id, input logic e_err, input logic [31:0] rd, input int c);
    ack_t e;
    e.id = id; e.err = e_err; e.rd = rd; e.cyc = c;
    ack_q.push_back(e);
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_req) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_acc_req", 64'd1, 64'd0);
        end else begin
          ea = acc_q.pop_front();
          chk("acc_gnt_id", 64'(gnt_id), 64'(ea.id));
          chk("acc_is_wr", 64'(acc_is_wr), 64'(ea.is_wr));
          chk("acc_addr", 64'(acc_addr), 64'(ea.addr));
          chk("acc_wdata", 64'(acc_wdata), 64'(ea.wd));
          chk("acc_bit_en", 64'(acc_be), 64'(ea.be));
          if (ea.cyc >= 0) chk("acc_cycle", 64'(cyc), 64'(ea.cyc));
        end
      end
      if (ack != 2'b00) begin
        chk("ack_onehot", 64'($countones(ack)), 64'd1);
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          eb = ack_q.pop_front();
          chk("ack_owner", 64'(ack), 64'd1 << eb.id);
          chk("ack_gnt_id", 64'(gnt_id), 64'(eb.id));
          chk("ack_err", 64'(err), eb.err ? (64'd1 << eb.id) : 64'd0);
          chk("ack_rd_data", 64'(rd_data), 64'(eb.rd));
          if (eb.cyc >= 0) chk("ack_cycle", 64'(cyc), 64'(eb.cyc));
        end
      end else if (err != 2'b00) begin
        chk("err_without_ack", 64'(err), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({ack, err, acc_req, acc_is_wr, busy, gnt_id}), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_addr_wdata"}, 64'({acc_addr, acc_wdata}), 64'd0);
    chk({tag, "_bit_en"}, 64'(acc_be), 64'd0);
  endtask

  // Bridge model for one access: waits (bounded) for o_acc_req, then returns
  // the ack 'delay' cycles into WAIT_ACK. Returns in the DONE cycle.
  task automatic serve(input logic is_wr, input logic [31:0] data, input int delay);
    int i = 0;
    while (!acc_req && i < 40) begin
      tick();
      i++;
    end
    if (!acc_req) begin
      chk("acc_req_timeout", 64'd0, 64'd1);
      return;
    end
    tick();
    repeat (delay - 1) tick();
    if (is_wr) wr_ack = 1'b1;
    else       rd_ack = 1'b1;
    br_rd_data = data;
    tick();
    rd_ack     = 1'b0;
    wr_ack     = 1'b0;
    br_rd_data = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!busy && ack_q.size() == 0) return;
      tick();
    end
    chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; req = '0; req_is_wr = '0; byte_addr = '0;
    wr_data = '0; wr_bit_en = '0; rd_ack = 1'b0; wr_ack = 1'b0; br_rd_data = '0;
    repeat (3) tick();

    // Reset dominates pending requests.
    req = 2'b11;
    tick();
    check_all_zero("reset");

    // Contention from reset release: grants alternate 0,1,0,1.
    req_is_wr = 2'b00;
    byte_addr = {5'h0C, 5'h04};
    for (int k = 0; k < 4; k++) begin
      push_acc(k % 2, 1'b0, (k % 2 == 0) ? 5'h04 : 5'h0C, 32'h0, 32'h0, -1);
      push_ack(k % 2, 1'b0, 32'h1000_0000 + 32'(k), -1);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(1'b0, 32'h1000_0000 + 32'(k), 1);
      if (k == 2) req[0] = 1'b0;
      if (k == 3) req[1] = 1'b0;
    end
    wait_idle();

    // Spurious acks while idle.
    rd_ack = 1'b1; wr_ack = 1'b1; br_rd_data = 32'hBAD0_BAD0;
    repeat (2) tick();
    rd_ack = 1'b0; wr_ack = 1'b0; br_rd_data = '0;
    chk("idle_ack_no_busy", 64'(busy), 64'd0);
    tick();

    // Single read with exact latency, preceded by a wrong-type ack.
    byte_addr[4:0] = 5'h08; req[0] = 1'b1;
    n = cyc;
    push_acc(0, 1'b0, 5'h08, 32'h0, 32'h0, n + 1);
    push_ack(0, 1'b0, 32'hDEAD_BEEF, n + 4);
    tick();
    tick();
    wr_ack = 1'b1; br_rd_data = 32'h5555_5555;
    tick();
    chk("wrong_type_ack_still_busy", 64'(busy), 64'd1);
    wr_ack = 1'b0; rd_ack = 1'b1; br_rd_data = 32'hDEAD_BEEF;
    tick();
    rd_ack = 1'b0; br_rd_data = '0; req[0] = 1'b0;
    wait_idle();

    // Write from requester 1; inputs change and request drops after grant.
    byte_addr[9:5] = 5'h10; wr_data[63:32] = 32'h1234_5678;
    wr_bit_en[63:32] = 32'h0000_FFFF; req_is_wr[1] = 1'b1; req[1] = 1'b1;
    push_acc(1, 1'b1, 5'h10, 32'h1234_5678, 32'h0000_FFFF, -1);
    push_ack(1, 1'b0, 32'h0, -1);
    tick();
    req[1] = 1'b0; req_is_wr[1] = 1'b0; byte_addr[9:5] = 5'h1F;
    wr_data[63:32] = 32'hFFFF_FFFF; wr_bit_en[63:32] = 32'hFFFF_FFFF;
    serve(1'b1, 32'hFFFF_FFFF, 1);
    wait_idle();
    chk("addr_held_after_access", 64'(acc_addr), 64'h10);
    wr_data = '0; wr_bit_en = '0;

    // Watchdog timeout: o_ack 17 cycles after o_acc_req, then a late ack.
    byte_addr[4:0] = 5'h14; req[0] = 1'b1;
    n = cyc;
    push_acc(0, 1'b0, 5'h14, 32'h0, 32'h0, n + 1);
    push_ack(0, 1'b1, 32'h0, n + 18);
    tick();
    req[0] = 1'b0;
    repeat (17) tick();
    tick();
    rd_ack = 1'b1; br_rd_data = 32'h7777_7777;
    tick();
    rd_ack = 1'b0; br_rd_data = '0;
    chk("timeout_ack_seen", 64'(ack_q.size()), 64'd0);
    chk("late_ack_no_busy", 64'(busy), 64'd0);

    // Next request after the timeout is served normally.
    byte_addr[9:5] = 5'h03; req[1] = 1'b1;
    push_acc(1, 1'b0, 5'h03, 32'h0, 32'h0, -1);
    push_ack(1, 1'b0, 32'hCAFE_F00D, -1);
    serve(1'b0, 32'hCAFE_F00D, 2);
    req[1] = 1'b0;
    wait_idle();

    // Reset in WAIT_ACK aborts without o_ack and clears rr_ptr.
    byte_addr[4:0] = 5'h1A; req[0] = 1'b1;
    push_acc(0, 1'b0, 5'h1A, 32'h0, 32'h0, -1);
    tick();
    req[0] = 1'b0;
    tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1; rd_ack = 1'b1; br_rd_data = 32'h9999_9999;
    tick();
    rd_ack = 1'b0; br_rd_data = '0;
    chk("post_reset_idle", 64'(busy), 64'd0);
    // rr_ptr would be 1 without the reset; after it requester 0 wins first.
    byte_addr = {5'h02, 5'h01}; req = 2'b11;
    push_acc(0, 1'b0, 5'h01, 32'h0, 32'h0, -1);
    push_ack(0, 1'b0, 32'hA0A0_A0A0, -1);
    push_acc(1, 1'b0, 5'h02, 32'h0, 32'h0, -1);
    push_ack(1, 1'b0, 32'hB1B1_B1B1, -1);
    serve(1'b0, 32'hA0A0_A0A0, 1);
    req[0] = 1'b0;
    serve(1'b0, 32'hB1B1_B1B1, 1);
    req[1] = 1'b0;
    wait_idle();
    repeat (3) tick();

    chk("scoreboard_drained", 64'(acc_q.size() + ack_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
